// File: rtl/wb_regfile.sv
// Writeback stage of a five-stage Y86-style pipeline: the W pipeline register,
// the architectural register file with W-stage bypass, halt tracking and a retire counter.
module wb_regfile #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_stall,
  input  logic              w_bubble,
  input  logic [2:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [ADDR_W-1:0] m_dstE,
  input  logic [ADDR_W-1:0] m_dstM,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_val,
  output logic [2:0]        stat,
  output logic              halted,
  output logic [31:0]       retired
);

  localparam logic [ADDR_W-1:0] RNONE   = '1;
  localparam logic [ADDR_W-1:0] NREG_ID = ADDR_W'(NREG);
  localparam logic [2:0]        S_AOK   = 3'd1;
  localparam logic [3:0]        I_NOP   = 4'h1;

  logic [2:0]        stat_p1;
  logic [3:0]        icode_p1;
  logic [ADDR_W-1:0] dste_p1;
  logic [ADDR_W-1:0] dstm_p1;
  logic [DATA_W-1:0] vale_p1;
  logic [DATA_W-1:0] valm_p1;
  logic              vld_p1;
  logic              committed;
  logic              we;
  logic              w_load;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] arch_a;
  logic [DATA_W-1:0] arch_b;

  assign we     = vld_p1 && (stat_p1 == S_AOK) && !halted;
  assign w_load = !halted && !w_stall;
  assign stat   = stat_p1;

  // ---- stage p1: W pipeline register (stall dominates bubble) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_p1  <= S_AOK;
      icode_p1 <= I_NOP;
      dste_p1  <= RNONE;
      dstm_p1  <= RNONE;
      vale_p1  <= '0;
      valm_p1  <= '0;
      vld_p1   <= 1'b0;
    end else if (w_load) begin
      if (w_bubble) begin
        stat_p1  <= S_AOK;
        icode_p1 <= I_NOP;
        dste_p1  <= RNONE;
        dstm_p1  <= RNONE;
        vale_p1  <= '0;
        valm_p1  <= '0;
        vld_p1   <= 1'b0;
      end else begin
        stat_p1  <= m_stat;
        icode_p1 <= m_icode;
        dste_p1  <= m_dstE;
        dstm_p1  <= m_dstM;
        vale_p1  <= m_valE;
        valm_p1  <= m_valM;
        vld_p1   <= 1'b1;
      end
    end
  end

  // committed remembers that the current W content was already counted, so a
  // stalled instruction rewriting its results every cycle retires only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      committed <= 1'b0;
      halted    <= 1'b0;
      retired   <= '0;
    end else begin
      if (w_load) committed <= 1'b0;
      else if (we) committed <= 1'b1;
      if (vld_p1 && (stat_p1 != S_AOK) && !halted) halted <= 1'b1;
      if (we && !committed) retired <= retired + 32'd1;
    end
  end

  // ---- architectural state: the valM write overrides valE on a shared destination ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NREG; i++) begin
        if (dstm_p1 == ADDR_W'(i)) regs[i] <= valm_p1;
        else if (dste_p1 == ADDR_W'(i)) regs[i] <= vale_p1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] src,
                                            input logic [DATA_W-1:0] arch);
    if (src >= NREG_ID) return '0;
    if (we && (src == dstm_p1)) return valm_p1;
    if (we && (src == dste_p1)) return vale_p1;
    return arch;
  endfunction

  // IDs outside 0..NREG-1 never match the lookup loop and read as zero.
  always_comb begin
    arch_a  = '0;
    arch_b  = '0;
    dbg_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (srcA == ADDR_W'(i)) arch_a = regs[i];
      if (srcB == ADDR_W'(i)) arch_b = regs[i];
      if (dbg_sel == ADDR_W'(i)) dbg_val = regs[i];
    end
    valA = fwd(srcA, arch_a);
    valB = fwd(srcB, arch_b);
  end

  // A bubble always carries the nop icode.
  a_bubble_nop: assert property (@(posedge clk) disable iff (!rst_n)
    (vld_p1 || (icode_p1 == I_NOP)));

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// checked against an instruction-level model of the writeback stage.
module tb_wb_regfile;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int NR = 12;
  localparam logic [3:0] RN = 4'hF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_stall, w_bubble;
  logic [2:0]    m_stat;
  logic [3:0]    m_icode;
  logic [AW-1:0] m_dstE, m_dstM, srcA, srcB, dbg_sel;
  logic [DW-1:0] m_valE, m_valM, valA, valB, dbg_val;
  logic [2:0]    stat;
  logic          halted;
  logic [31:0]   retired;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
    .clk(clk), .rst_n(rst_n), .w_stall(w_stall), .w_bubble(w_bubble),
    .m_stat(m_stat), .m_icode(m_icode), .m_dstE(m_dstE), .m_dstM(m_dstM),
    .m_valE(m_valE), .m_valM(m_valM), .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB), .dbg_sel(dbg_sel), .dbg_val(dbg_val),
    .stat(stat), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    stat;
    logic [3:0]    icode;
    logic [3:0]    dste;
    logic [3:0]    dstm;
    logic [DW-1:0] vale;
    logic [DW-1:0] valm;
    logic          valid;
  } w_t;

  // Reference model: the instruction sitting in W, whether it has been counted,
  // the register array, the halt flag and the retire count.
  w_t            mw;
  logic [DW-1:0] mr [NR];
  bit            mhalt, mcounted;
  logic [31:0]   mret;
  int            n_cmp, n_bad;

  function automatic w_t bubble_w();
    w_t b;
    b.stat = 3'd1; b.icode = 4'h1; b.dste = RN; b.dstm = RN;
    b.vale = '0; b.valm = '0; b.valid = 1'b0;
    return b;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) mr[i] = '0;
    mw = bubble_w(); mhalt = 0; mcounted = 0; mret = '0;
  endfunction

  function automatic bit m_we();
    return mw.valid && (mw.stat == 3'd1) && !mhalt;
  endfunction

  function automatic logic [DW-1:0] m_arch(input logic [3:0] id);
    if (int'(id) >= NR) return '0;
    return mr[int'(id)];
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [3:0] id);
    if (int'(id) >= NR) return '0;
    if (m_we() && mw.dstm == id) return mw.valm;
    if (m_we() && mw.dste == id) return mw.vale;
    return mr[int'(id)];
  endfunction

  function automatic void m_edge();
    bit we, was_halted;
    w_t cur;
    we = m_we(); was_halted = mhalt; cur = mw;
    if (we) begin
      if (int'(cur.dste) < NR) mr[int'(cur.dste)] = cur.vale;
      if (int'(cur.dstm) < NR) mr[int'(cur.dstm)] = cur.valm;
      if (!mcounted) mret = mret + 32'd1;
      mcounted = 1;
    end
    if (!was_halted && cur.valid && cur.stat != 3'd1) mhalt = 1;
    if (!was_halted && !w_stall) begin
      mcounted = 0;
      if (w_bubble) mw = bubble_w();
      else begin
        mw.stat = m_stat; mw.icode = m_icode; mw.dste = m_dstE; mw.dstm = m_dstM;
        mw.vale = m_valE; mw.valm = m_valM; mw.valid = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic set_load(input logic [2:0] s, input logic [3:0] ic, input logic [3:0] de,
                          input logic [3:0] dm, input logic [DW-1:0] ve, input logic [DW-1:0] vm);
    m_stat = s; m_icode = ic; m_dstE = de; m_dstM = dm; m_valE = ve; m_valM = vm;
    w_stall = 1'b0; w_bubble = 1'b0;
  endtask

  task automatic set_bubble();
    w_stall = 1'b0; w_bubble = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_bubble();
    m_stat = 3'd1; m_icode = 4'h0; m_dstE = RN; m_dstM = RN; m_valE = '0; m_valM = '0;
    srcA = 4'd0; srcB = 4'd3; dbg_sel = 4'd0;
    m_reset();
    #7;
    n_cmp++; if (valA !== '0) begin n_bad++; $display("FAIL reset_valA: got %0h want 0", valA); end
    n_cmp++; if (valB !== '0) begin n_bad++; $display("FAIL reset_valB: got %0h want 0", valB); end
    n_cmp++; if (stat !== 3'd1) begin n_bad++; $display("FAIL reset_stat: got %0d want 1", stat); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %0b want 0", halted); end
    n_cmp++; if (retired !== 32'd0) begin n_bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i); #0.1;
      n_cmp++; if (dbg_val !== '0) begin n_bad++; $display("FAIL reset_dbg[%0d]: got %0h want 0", i, dbg_val); end
    end
    #0.5 rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    set_load(3'd1, 4'h3, 4'd5, RN, 64'd90, 64'd0);
    tick();
    srcA = 4'd5; dbg_sel = 4'd5; #1;
    n_cmp++; if (valA !== 64'd90) begin n_bad++; $display("FAIL bypass_valA: got %0d want 90", valA); end
    n_cmp++; if (dbg_val !== 64'd0) begin n_bad++; $display("FAIL bypass_dbg_nobypass: got %0d want 0", dbg_val); end
    set_bubble();
    tick();
    n_cmp++; if (dbg_val !== 64'd90) begin n_bad++; $display("FAIL bypass_dbg_after: got %0d want 90", dbg_val); end
    n_cmp++; if (retired !== 32'd1) begin n_bad++; $display("FAIL bypass_retired: got %0d want 1", retired); end
  endtask

  task automatic test_popq();
    set_load(3'd1, 4'hB, 4'd4, 4'd4, 64'd10, 64'd140);
    tick();
    srcB = 4'd4; #1;
    n_cmp++; if (valB !== 64'd140) begin n_bad++; $display("FAIL popq_valB_bypass: got %0d want 140", valB); end
    set_bubble();
    tick();
    dbg_sel = 4'd4; #1;
    n_cmp++; if (dbg_val !== 64'd140) begin n_bad++; $display("FAIL popq_R4: got %0d want 140", dbg_val); end
    n_cmp++; if (valB !== 64'd140) begin n_bad++; $display("FAIL popq_valB_arch: got %0d want 140", valB); end
  endtask

  task automatic test_stall();
    logic [31:0] base;
    base = mret;
    set_load(3'd1, 4'h2, 4'd6, RN, 64'd80, 64'd0);
    tick();
    w_stall = 1'b1; w_bubble = 1'b1; m_dstE = 4'd6; m_valE = 64'd999;
    dbg_sel = 4'd6;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (dbg_val !== 64'd80) begin n_bad++; $display("FAIL stall_R6[%0d]: got %0d want 80", k, dbg_val); end
      n_cmp++; if (retired !== base + 32'd1) begin n_bad++; $display("FAIL stall_retired[%0d]: got %0d want %0d", k, retired, base + 32'd1); end
    end
    set_bubble();
    tick();
    tick();
    n_cmp++; if (retired !== base + 32'd1) begin n_bad++; $display("FAIL stall_release_retired: got %0d want %0d", retired, base + 32'd1); end
    n_cmp++; if (dbg_val !== 64'd80) begin n_bad++; $display("FAIL stall_release_R6: got %0d want 80", dbg_val); end
    n_cmp++; if (stat !== 3'd1) begin n_bad++; $display("FAIL stall_release_stat: got %0d want 1", stat); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      w_stall  = ($urandom_range(0, 5) == 0);
      w_bubble = ($urandom_range(0, 5) == 0);
      m_stat   = 3'd1;
      m_icode  = 4'($urandom_range(0, 15));
      m_dstE   = 4'($urandom_range(0, 15));
      m_dstM   = ($urandom_range(0, 1) == 0) ? RN : 4'($urandom_range(0, 15));
      m_valE   = {$urandom(), $urandom()};
      m_valM   = {$urandom(), $urandom()};
      srcA     = ($urandom_range(0, 2) == 0) ? mw.dste : 4'($urandom_range(0, 15));
      srcB     = ($urandom_range(0, 2) == 0) ? mw.dstm : 4'($urandom_range(0, 15));
      dbg_sel  = 4'($urandom_range(0, 15));
      #1;
      n_cmp++; if (valA !== m_read(srcA)) begin n_bad++; $display("FAIL rand_valA c=%0d src=%0d: got %0h want %0h", c, srcA, valA, m_read(srcA)); end
      n_cmp++; if (valB !== m_read(srcB)) begin n_bad++; $display("FAIL rand_valB c=%0d src=%0d: got %0h want %0h", c, srcB, valB, m_read(srcB)); end
      n_cmp++; if (dbg_val !== m_arch(dbg_sel)) begin n_bad++; $display("FAIL rand_dbg c=%0d sel=%0d: got %0h want %0h", c, dbg_sel, dbg_val, m_arch(dbg_sel)); end
      n_cmp++; if (stat !== mw.stat) begin n_bad++; $display("FAIL rand_stat c=%0d: got %0d want %0d", c, stat, mw.stat); end
      tick();
      n_cmp++; if (retired !== mret) begin n_bad++; $display("FAIL rand_retired c=%0d: got %0d want %0d", c, retired, mret); end
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rand_halted c=%0d: got %0b want 0", c, halted); end
    end
  endtask

  task automatic test_halt();
    logic [31:0] base;
    set_load(3'd1, 4'h3, 4'd2, RN, 64'd33, 64'd0);
    tick();
    set_load(3'd2, 4'h0, 4'd2, RN, 64'd7, 64'd0);
    tick();
    base = mret;
    w_stall = 1'b1;
    tick();
    dbg_sel = 4'd2; srcA = 4'd2; #1;
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_set: got %0b want 1", halted); end
    n_cmp++; if (dbg_val !== 64'd33) begin n_bad++; $display("FAIL halt_R2: got %0d want 33", dbg_val); end
    n_cmp++; if (retired !== base) begin n_bad++; $display("FAIL halt_retired: got %0d want %0d", retired, base); end
    n_cmp++; if (stat !== 3'd2) begin n_bad++; $display("FAIL halt_stat: got %0d want 2", stat); end
    for (int k = 0; k < 2; k++) begin
      set_load(3'd1, 4'h3, 4'd2, 4'd2, 64'd55, 64'd66);
      tick();
      n_cmp++; if (stat !== 3'd2) begin n_bad++; $display("FAIL halt_frozen_stat[%0d]: got %0d want 2", k, stat); end
      n_cmp++; if (valA !== 64'd33) begin n_bad++; $display("FAIL halt_frozen_valA[%0d]: got %0d want 33", k, valA); end
      n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_sticky[%0d]: got %0b want 1", k, halted); end
      n_cmp++; if (retired !== base) begin n_bad++; $display("FAIL halt_frozen_retired[%0d]: got %0d want %0d", k, retired, base); end
    end
  endtask

  task automatic test_async_reset();
    w_stall = 1'b1;
    srcA = 4'd2; srcB = 4'd6; dbg_sel = 4'd2;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL areset_halted: got %0b want 0", halted); end
    n_cmp++; if (retired !== 32'd0) begin n_bad++; $display("FAIL areset_retired: got %0d want 0", retired); end
    n_cmp++; if (stat !== 3'd1) begin n_bad++; $display("FAIL areset_stat: got %0d want 1", stat); end
    n_cmp++; if (valA !== '0) begin n_bad++; $display("FAIL areset_valA: got %0h want 0", valA); end
    n_cmp++; if (valB !== '0) begin n_bad++; $display("FAIL areset_valB: got %0h want 0", valB); end
    n_cmp++; if (dbg_val !== '0) begin n_bad++; $display("FAIL areset_dbg: got %0h want 0", dbg_val); end
    #1 rst_n = 1'b1;
    set_load(3'd1, 4'h3, 4'd7, RN, 64'd123, 64'd0);
    tick();
    srcA = 4'd7; dbg_sel = 4'd7; #1;
    n_cmp++; if (valA !== 64'd123) begin n_bad++; $display("FAIL after_reset_valA: got %0d want 123", valA); end
    set_bubble();
    tick();
    n_cmp++; if (retired !== 32'd1) begin n_bad++; $display("FAIL after_reset_retired: got %0d want 1", retired); end
    n_cmp++; if (dbg_val !== 64'd123) begin n_bad++; $display("FAIL after_reset_R7: got %0d want 123", dbg_val); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_bypass();
    test_popq();
    test_stall();
    test_random();
    test_halt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
